// File: rtl/swing_ctrl.sv
// Balance-rail swing controller: synced/debounced pins, swing FSM, decaying ADJUST oscillation.
// Optional macro SWING_AUTORESTART_EN: ADJUST completion returns to WAIT instead of IDLE.
module swing_ctrl #(
    parameter int ROUND    = 6,
    parameter int CNT_W    = 4,
    parameter int TMR_W    = 27,
    parameter int PERIOD   = 100_000_000,
    parameter int MIN_HP   = 1_000_000,
    parameter int DECAY_SH = 3,
    parameter int DEB_LEN  = 16,
    parameter int TIMEOUT  = 100_000_000
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             key,
    input  logic             catcher,
    input  logic             jockey_r,
    input  logic             jockey_l,
    input  logic             abort,
    output logic             direct,
    output logic             enable,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] round_cnt,
    output logic [2:0]       state
);

    localparam logic [6:0] ST_IDLE  = 7'b0000001;
    localparam logic [6:0] ST_BAL   = 7'b0000010;
    localparam logic [6:0] ST_WAIT  = 7'b0000100;
    localparam logic [6:0] ST_AUTOR = 7'b0001000;
    localparam logic [6:0] ST_AUTOL = 7'b0010000;
    localparam logic [6:0] ST_ADJ   = 7'b0100000;
    localparam logic [6:0] ST_FAULT = 7'b1000000;

    localparam int              DB_W     = $clog2(DEB_LEN) + 1;
    localparam logic [DB_W-1:0] DEB_LAST = DB_W'(DEB_LEN - 1);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);

    localparam logic [TMR_W-1:0] PERIOD_C = TMR_W'(PERIOD);
    localparam logic [TMR_W-1:0] MIN_HP_C = TMR_W'(MIN_HP);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
    localparam logic [CNT_W-1:0] ROUND_C  = CNT_W'(ROUND);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    function automatic logic [2:0] encode_state(input logic [6:0] oh);
        logic [2:0] code;
        code = '0;
        for (int i = 0; i < 7; i++) begin
            if (oh[i]) code = 3'(i);
        end
        return code;
    endfunction

    // Bit 0 is key (idles low); bits 1..3 are catcher, jockey_r, jockey_l (idle high).
    logic [3:0]      sync1_q, sync2_q;
    logic            key_prev_q;
    logic [2:0]      deb_q, deb_d;
    logic [DB_W-1:0] cnt_q [3];
    logic [DB_W-1:0] cnt_d [3];

    logic [6:0]       state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [TMR_W-1:0] dwell_q, dwell_d;
    logic [TMR_W-1:0] hp_q, hp_d, ph_q, ph_d;
    logic             dir_a_q, dir_a_d;

    logic             state_o_unused;
    logic [2:0]       state_o_q;
    logic             direct_o_q, enable_o_q, busy_o_q, fault_o_q;
    logic [CNT_W-1:0] round_o_q;

    logic             key_edge, catch_hit, jr_hit, jl_hit, both_hit;
    logic             dwell_exp, in_timed, ph_wrap, adj_done;
    logic [TMR_W-1:0] hp_dec, hp_new;
    logic [CNT_W-1:0] round_inc;

    assign state_o_unused = 1'b0;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i+1] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i+1];
                else                      cnt_d[i] = cnt_q[i] + DB_ONE;
            end
        end
    end

    assign key_edge  = sync2_q[0] & ~key_prev_q;
    assign catch_hit = ~deb_q[0];
    assign jr_hit    = ~deb_q[1];
    assign jl_hit    = ~deb_q[2];
    assign both_hit  = jr_hit & jl_hit;
    assign in_timed  = |(state_q & (ST_BAL | ST_AUTOR | ST_AUTOL));
    assign dwell_exp = in_timed && (dwell_q == TO_LAST);
    assign round_inc = round_q + C_ONE;

    assign hp_dec   = hp_q >> DECAY_SH;
    assign hp_new   = hp_q - hp_dec;
    assign ph_wrap  = (ph_q == hp_q - T_ONE);
    assign adj_done = (state_q == ST_ADJ) && ph_wrap &&
                      ((hp_new < MIN_HP_C) || (hp_dec == '0));

    // Abort overrides fault conditions, which override normal progress.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE:  if (key_edge) state_d = ST_BAL;
            ST_BAL: begin
                if (dwell_exp)      state_d = ST_FAULT;
                else if (catch_hit) state_d = ST_WAIT;
            end
            ST_WAIT:  if (key_edge) state_d = ST_AUTOR;
            ST_AUTOR: begin
                if (both_hit || dwell_exp) state_d = ST_FAULT;
                else if (jr_hit) begin
                    state_d = ST_AUTOL;
                    round_d = round_inc;
                end
            end
            ST_AUTOL: begin
                if (both_hit || dwell_exp) state_d = ST_FAULT;
                else if (jl_hit) begin
                    round_d = round_inc;
                    state_d = (round_inc == ROUND_C) ? ST_ADJ : ST_AUTOR;
                end
            end
            ST_ADJ: begin
                if (adj_done) begin
`ifdef SWING_AUTORESTART_EN
                    state_d = ST_WAIT;
                    round_d = '0;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_FAULT: if (key_edge) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
        if (state_d == ST_IDLE) round_d = '0;
    end

    always_comb begin
        dwell_d = '0;
        if (in_timed && (state_d == state_q)) dwell_d = dwell_q + T_ONE;
    end

    // Timers are live only while staying in ADJUST; any exit clears them.
    always_comb begin
        hp_d    = hp_q;
        ph_d    = ph_q + T_ONE;
        dir_a_d = dir_a_q;
        if (state_d != ST_ADJ) begin
            hp_d    = '0;
            ph_d    = '0;
            dir_a_d = 1'b0;
        end else if (state_q != ST_ADJ) begin
            hp_d    = PERIOD_C;
            ph_d    = '0;
            dir_a_d = 1'b1;
        end else if (ph_wrap) begin
            hp_d    = hp_new;
            ph_d    = '0;
            dir_a_d = ~dir_a_q;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync1_q    <= 4'b1110;
            sync2_q    <= 4'b1110;
            key_prev_q <= 1'b0;
            deb_q      <= 3'b111;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q    <= ST_IDLE;
            round_q    <= '0;
            dwell_q    <= '0;
            hp_q       <= '0;
            ph_q       <= '0;
            dir_a_q    <= 1'b0;
        end else begin
            sync1_q    <= {jockey_l, jockey_r, catcher, key};
            sync2_q    <= sync1_q;
            key_prev_q <= sync2_q[0];
            deb_q      <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            round_q    <= round_d;
            dwell_q    <= dwell_d;
            hp_q       <= hp_d;
            ph_q       <= ph_d;
            dir_a_q    <= dir_a_d;
        end
    end

    // Output register: one cycle behind the internal state.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_o_q  <= '0;
            direct_o_q <= 1'b0;
            enable_o_q <= 1'b0;
            busy_o_q   <= 1'b0;
            fault_o_q  <= 1'b0;
            round_o_q  <= '0;
        end else begin
            state_o_q  <= encode_state(state_q);
            direct_o_q <= (state_q == ST_AUTOR) ||
                          ((state_q == ST_ADJ) && dir_a_q) || state_o_unused;
            enable_o_q <= |(state_q & (ST_BAL | ST_AUTOR | ST_AUTOL | ST_ADJ));
            busy_o_q   <= !((state_q == ST_IDLE) || (state_q == ST_FAULT));
            fault_o_q  <= (state_q == ST_FAULT);
            round_o_q  <= round_q;
        end
    end

    assign state     = state_o_q;
    assign direct    = direct_o_q;
    assign enable    = enable_o_q;
    assign busy      = busy_o_q;
    assign fault     = fault_o_q;
    assign round_cnt = round_o_q;

endmodule
